// File: rtl/vae_fixed_pkg.sv
`default_nettype none
// ============================================================================
// Module  : vae_fixed_pkg
// Purpose : Shared Q6.10 fixed-point constants and the neuron front-end state
//           encoding used by the VAE encoder/decoder layer blocks.
// Contents: DATA_W, FRAC_W, Q610_MAX/MIN/ONE, neuron_state_t
// Revision: 1.0  initial release
// ============================================================================
package vae_fixed_pkg;

  localparam int DATA_W = 16;
  localparam int FRAC_W = 10;

  localparam logic signed [DATA_W-1:0] Q610_MAX = 16'sh7FFF;
  localparam logic signed [DATA_W-1:0] Q610_MIN = 16'sh8000;
  localparam logic signed [DATA_W-1:0] Q610_ONE = 16'sh0400;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACCUM = 3'd1,
    BIAS  = 3'd2,
    SAT   = 3'd3,
    ACT   = 3'd4,
    DONE  = 3'd5
  } neuron_state_t;

endpackage : vae_fixed_pkg
`default_nettype wire

// File: rtl/q610_round_sat.sv
`default_nettype none
// ============================================================================
// Module  : q610_round_sat
// Purpose : Combinational reduction of a Q(ACC_W-20).20 accumulator to a
//           saturated Q6.10 word: optional round-half-up, arithmetic shift by
//           FRAC_W, clamp to the signed DATA_W range.
// Ports   : acc (in,  ACC_W)  signed accumulator
//           q   (out, DATA_W) rounded/saturated result
// Config  : PREACT_ROUND_EN defined   -> add 1<<(FRAC_W-1) before the shift
//           PREACT_ROUND_EN undefined -> plain shift (truncate toward -inf)
// Revision: 1.0  initial release
// ============================================================================
module q610_round_sat #(
  parameter int ACC_W  = 40,
  parameter int DATA_W = 16,
  parameter int FRAC_W = 10
) (
  input  logic signed [ACC_W-1:0]  acc,
  output logic signed [DATA_W-1:0] q
);

  // One guard bit so the rounding addend can never wrap the accumulator.
  localparam int EXT_W = ACC_W + 1;

  localparam logic signed [EXT_W-1:0] MAX_EXT =
    {{(EXT_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] MIN_EXT =
    {{(EXT_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

`ifdef PREACT_ROUND_EN
  localparam logic signed [EXT_W-1:0] HALF_LSB =
    {{(EXT_W-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};
`else
  localparam logic signed [EXT_W-1:0] HALF_LSB = '0;
`endif

  logic signed [EXT_W-1:0] biased;
  logic signed [EXT_W-1:0] shifted;

  always_comb begin
    biased  = {acc[ACC_W-1], acc} + HALF_LSB;
    shifted = biased >>> FRAC_W;
    if (shifted > MAX_EXT) begin
      q = MAX_EXT[DATA_W-1:0];
    end else if (shifted < MIN_EXT) begin
      q = MIN_EXT[DATA_W-1:0];
    end else begin
      q = shifted[DATA_W-1:0];
    end
  end

endmodule : q610_round_sat
`default_nettype wire

// File: rtl/neuron_preact_seq.sv
`default_nettype none
// ============================================================================
// Module  : neuron_preact_seq
// Purpose : Serial neuron front-end. Accumulates N_INPUTS x*w products,
//           adds the bias, rounds/saturates to Q6.10, drives the sigmoid for
//           SIG_HOLD cycles and captures its result.
// Ports   : clk, rst (async, active-high)
//           start      in   begin one neuron (accepted in IDLE only)
//           in_valid   in   x_in/w_in beat valid
//           in_ready   out  high throughout ACCUM
//           x_in, w_in in   signed Q6.10 activation / weight
//           bias       in   signed Q6.10 bias, latched on accepted start
//           busy       out  high in every state except IDLE
//           act_x      out  saturated pre-activation to sigmoid x
//           sigmoid_en out  high for exactly SIG_HOLD cycles
//           sig_y      in   sigmoid result
//           y_out      out  captured activation
//           done       out  one-cycle completion pulse
// Config  : PREACT_ROUND_EN selects round-half-up in the SAT stage
//           (implemented in q610_round_sat).
// Revision: 1.0  initial release
// ============================================================================
module neuron_preact_seq #(
  parameter int N_INPUTS = 8,
  parameter int DATA_W   = vae_fixed_pkg::DATA_W,
  parameter int FRAC_W   = vae_fixed_pkg::FRAC_W,
  parameter int ACC_W    = 40,
  parameter int SIG_HOLD = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] x_in,
  input  logic signed [DATA_W-1:0] w_in,
  input  logic signed [DATA_W-1:0] bias,
  output logic                     busy,
  output logic signed [DATA_W-1:0] act_x,
  output logic                     sigmoid_en,
  input  logic signed [DATA_W-1:0] sig_y,
  output logic signed [DATA_W-1:0] y_out,
  output logic                     done
);

  import vae_fixed_pkg::*;

  localparam int CNT_W  = $clog2(N_INPUTS + 1);
  localparam int HOLD_W = $clog2(SIG_HOLD + 1);
  localparam int PROD_W = 2 * DATA_W;

  neuron_state_t state;
  neuron_state_t state_nx;

  logic signed [ACC_W-1:0]  acc;
  logic        [CNT_W-1:0]  count;
  logic        [HOLD_W-1:0] hold_cnt;
  logic signed [DATA_W-1:0] bias_q;
  logic signed [PROD_W-1:0] prod;
  logic signed [DATA_W-1:0] sat_q;
  logic                     beat;
  logic                     last_beat;
  logic                     last_hold;

  // Full-precision Q12.20 product; sign-extended into the Q20.20 accumulator.
  assign prod      = x_in * w_in;
  assign beat      = in_valid && in_ready;
  assign last_beat = beat && (count == CNT_W'(N_INPUTS - 1));
  assign last_hold = (hold_cnt == HOLD_W'(SIG_HOLD - 1));

  q610_round_sat #(
    .ACC_W  (ACC_W),
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W)
  ) u_round_sat (
    .acc (acc),
    .q   (sat_q)
  );

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and state-decoded outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_nx   = state;
    in_ready   = 1'b0;
    busy       = 1'b1;
    sigmoid_en = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nx = ACCUM;
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (last_beat) state_nx = BIAS;
      end
      BIAS: state_nx = SAT;
      SAT:  state_nx = ACT;
      ACT: begin
        sigmoid_en = 1'b1;
        if (last_hold) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: begin
        busy     = 1'b0;
        state_nx = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      count    <= '0;
      hold_cnt <= '0;
      bias_q   <= '0;
      act_x    <= '0;
      y_out    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc    <= '0;
            count  <= '0;
            bias_q <= bias;
          end
        end
        ACCUM: begin
          if (beat) begin
            acc   <= acc + ACC_W'(prod);
            count <= count + CNT_W'(1);
          end
        end
        BIAS: begin
          // Align the Q6.10 bias to the Q.20 accumulator scale.
          acc <= acc + (ACC_W'(bias_q) <<< FRAC_W);
        end
        SAT: begin
          act_x    <= sat_q;
          hold_cnt <= '0;
        end
        ACT: begin
          hold_cnt <= hold_cnt + HOLD_W'(1);
          // Sample the sigmoid on the edge that closes its last enabled cycle.
          if (last_hold) y_out <= sig_y;
        end
        default: ;
      endcase
    end
  end

endmodule : neuron_preact_seq
`default_nettype wire
